// File: rtl/reg_rr_write_arbiter_pkg.sv
// rtl/reg_rr_write_arbiter_pkg.sv - shared state encoding and index-width helper for the write arbiter
package reg_rr_write_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_rr_write_arbiter_if.sv
// rtl/reg_rr_write_arbiter_if.sv - requester/arbiter bundle: request, lock, data in; grant, ack, word out
interface reg_rr_write_arbiter_if #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 4
);
    logic [N_REQ-1:0]            REQ;
    logic [N_REQ-1:0]            LOCK;
    logic [N_REQ*DATA_WIDTH-1:0] D;
    logic [N_REQ-1:0]            GNT;
    logic [N_REQ-1:0]            ACK;
    logic [DATA_WIDTH-1:0]       Q;
    logic                        BUSY;

    modport master (output REQ, LOCK, D, input GNT, ACK, Q, BUSY);
    modport slave  (input REQ, LOCK, D, output GNT, ACK, Q, BUSY);
endinterface

// File: rtl/reg_rr_write_arbiter_register.sv
// rtl/reg_rr_write_arbiter_register.sv - enable-gated storage register with synchronous reset value
module reg_rr_write_arbiter_register #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = en ? d : q_q;
    end

    always_ff @(posedge clk) begin
        if (rst) q_q <= RESET_VAL;
        else     q_q <= q_d;
    end

    assign q = q_q;
endmodule

// File: rtl/reg_rr_write_arbiter_rr_pick.sv
// rtl/reg_rr_write_arbiter_rr_pick.sv - combinational round-robin pick from pointer upward with wrap
module reg_rr_write_arbiter_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    input  logic [N_REQ-1:0] excl,
    output logic             valid,
    output logic [N_REQ-1:0] onehot,
    output logic [IDX_W-1:0] idx
);
    logic [N_REQ-1:0] cand;
    logic [IDX_W-1:0] c;

    assign cand = req & ~excl;

    always_comb begin
        valid  = 1'b0;
        onehot = '0;
        idx    = '0;
        c      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            c = IDX_W'((int'(ptr) + k) % N_REQ);
            if (!valid && cand[c]) begin
                valid     = 1'b1;
                onehot[c] = 1'b1;
                idx       = c;
            end
        end
    end
endmodule

// File: rtl/reg_rr_write_arbiter.sv
// rtl/reg_rr_write_arbiter.sv - round-robin shared register writer with bounded LOCK burst ownership
module reg_rr_write_arbiter
    import reg_rr_write_arbiter_pkg::*;
#(
    parameter int                    DATA_WIDTH = 4,
    parameter int                    N_REQ      = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0,
    parameter int                    MAX_HOLD   = 8
) (
    input  logic                  C,
    input  logic                  R,
    reg_rr_write_arbiter_if.slave bus
);
    localparam int IDX_W  = idx_width(N_REQ);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [N_REQ-1:0]    ack_q, ack_d;
    logic                busy_q, busy_d;

    logic                  we;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] q_word;
    logic [N_REQ-1:0]      excl;
    logic                  stay;
    logic                  pick_valid;
    logic [N_REQ-1:0]      pick_oh;
    logic [IDX_W-1:0]      pick_idx;
    logic [DATA_WIDTH-1:0] d_slice [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_slice
        assign d_slice[i] = bus.D[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // The current owner is masked out so a release edge hands straight to someone else.
    always_comb begin
        excl = '0;
        if (state_q == ST_OWNED) excl[owner_q] = 1'b1;
    end

    reg_rr_write_arbiter_rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
        .req    (bus.REQ),
        .ptr    (ptr_q),
        .excl   (excl),
        .valid  (pick_valid),
        .onehot (pick_oh),
        .idx    (pick_idx)
    );

    assign stay = (state_q == ST_OWNED) && bus.LOCK[owner_q] && (hold_q < HOLD_W'(MAX_HOLD));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        hold_d  = hold_q;
        gnt_d   = '0;
        ack_d   = '0;
        we      = 1'b0;
        wdata   = d_slice[owner_q];
        if (stay) begin
            gnt_d  = gnt_q;
            hold_d = hold_q + HOLD_W'(1);
            if (bus.REQ[owner_q]) begin
                we             = 1'b1;
                ack_d[owner_q] = 1'b1;
            end
        end else if (pick_valid) begin
            we      = 1'b1;
            wdata   = d_slice[pick_idx];
            ack_d   = pick_oh;
            gnt_d   = pick_oh;
            owner_d = pick_idx;
            ptr_d   = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
            if (bus.LOCK[pick_idx]) begin
                state_d = ST_OWNED;
                hold_d  = HOLD_W'(1);
            end else begin
                state_d = ST_IDLE;
                hold_d  = '0;
            end
        end else begin
            state_d = ST_IDLE;
            hold_d  = '0;
        end
        busy_d = (state_d == ST_OWNED);
    end

    always_ff @(posedge C) begin
        if (R) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            hold_q  <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    reg_rr_write_arbiter_register #(.WIDTH(DATA_WIDTH), .RESET_VAL(RESET_VAL)) u_store (
        .clk (C),
        .rst (R),
        .en  (we),
        .d   (wdata),
        .q   (q_word)
    );

    assign bus.Q    = q_word;
    assign bus.GNT  = gnt_q;
    assign bus.ACK  = ack_q;
    assign bus.BUSY = busy_q;
endmodule
